nested_if_pipe: RTL and testbench

- Parametrised, pipelined successor of the combinational nested-if golden block used by the CFG front-end regression suite.
- Evaluates the same priority if/else-if tree (x from b/c/d/f, y from e or a default) at WIDTH bits.
- Registers it behind a 2-stage valid/ready pipeline.
- Adds a sticky-y mode and a taken-branch indicator, so the CFG flow is exercised on sequential, stall-aware control.

---
 rtl/nested_if_pkg.sv | 13 +
 rtl/nested_if_sel.sv | 63 ++++++
 rtl/nested_if_pipe.sv | 133 +++++++++++++
 tb/tb_nested_if_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nested_if_pkg.sv
// nested_if_pkg: shared types and constants for the nested_if_pipe block.
//   branch_t : 2-bit code naming which leg of the selection tree produced x.
//   BR_ELSE (outer else, x = f), BR_B, BR_C, BR_D (inner legs, x = b/c/d).
package nested_if_pkg;

  typedef logic [1:0] branch_t;

  localparam branch_t BR_ELSE = 2'd0;
  localparam branch_t BR_B    = 2'd1;
  localparam branch_t BR_C    = 2'd2;
  localparam branch_t BR_D    = 2'd3;

endpackage

// File: rtl/nested_if_sel.sv
// nested_if_sel: combinational priority if/else-if selection tree.
// Ports:
//   a..f    in  WIDTH  operands
//   mode    in  1      0 = default y on the outer else, 1 = y_hold on the outer else
//   y_hold  in  WIDTH  sticky y value kept by the parent
//   x, y    out WIDTH  selected operands
//   branch  out 2      leg taken (see nested_if_pkg)
// All threshold compares are unsigned at WIDTH+1 bits so a+1 never wraps.
module nested_if_sel
  import nested_if_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int TH_LO     = 1,
  parameter int TH_MID    = 2,
  parameter int TH_HI     = 3,
  parameter int Y_DEFAULT = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic             mode,
  input  logic [WIDTH-1:0] y_hold,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output branch_t          branch
);

  localparam logic [WIDTH:0]   TH_LO_W  = (WIDTH+1)'(TH_LO);
  localparam logic [WIDTH:0]   TH_MID_W = (WIDTH+1)'(TH_MID);
  localparam logic [WIDTH:0]   TH_HI_W  = (WIDTH+1)'(TH_HI);
  localparam logic [WIDTH-1:0] Y_DEF_W  = WIDTH'(Y_DEFAULT);

  logic [WIDTH:0] a_w;
  logic [WIDTH:0] a_p1;

  assign a_w  = {1'b0, a};
  assign a_p1 = a_w + (WIDTH+1)'(1);

  always_comb begin
    x      = f;
    y      = Y_DEF_W;
    branch = BR_ELSE;
    if (a_w > TH_LO_W) begin
      y = e;
      if (a_w > TH_MID_W) begin
        x      = b;
        branch = BR_B;
      end else if (a_p1 > TH_HI_W) begin
        x      = c;
        branch = BR_C;
      end else begin
        x      = d;
        branch = BR_D;
      end
    end else if (mode) begin
      y = y_hold;
    end
  end

endmodule

// File: rtl/nested_if_pipe.sv
// nested_if_pipe: nested-if selection tree behind a 2-stage valid/ready pipe.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid / in_ready  input handshake; mode and a..f travel with it
//   out_valid / out_ready output handshake for o1, o2, branch
//   o1 = x + a, o2 = y + a (WIDTH+1 bits, no truncation), branch = leg taken
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Outputs are held stable while out_valid && !out_ready. in_ready depends
// only on pipeline state and out_ready, never on in_valid.
//
// y_hold captures e on every accepted input that takes the outer-if leg, so
// a following sticky-mode transaction sees the last accepted e even while
// its predecessor is still in flight.
module nested_if_pipe
  import nested_if_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int TH_LO     = 1,
  parameter int TH_MID    = 2,
  parameter int TH_HI     = 3,
  parameter int Y_DEFAULT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   o1,
  output logic [WIDTH:0]   o2,
  output branch_t          branch
);

  localparam logic [WIDTH-1:0] Y_DEF_W = WIDTH'(Y_DEFAULT);

  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  branch_t          sel_branch;
  logic [WIDTH-1:0] y_hold;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [WIDTH-1:0] s1_a;
  branch_t          s1_branch;

  logic             s2_valid;
  logic [WIDTH:0]   s2_o1;
  logic [WIDTH:0]   s2_o2;
  branch_t          s2_branch;

  logic             s2_load;
  logic             accept;

  nested_if_sel #(
    .WIDTH    (WIDTH),
    .TH_LO    (TH_LO),
    .TH_MID   (TH_MID),
    .TH_HI    (TH_HI),
    .Y_DEFAULT(Y_DEFAULT)
  ) u_sel (
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .mode  (mode),
    .y_hold(y_hold),
    .x     (sel_x),
    .y     (sel_y),
    .branch(sel_branch)
  );

  // S2 can take new data when empty or when its contents leave this cycle;
  // S1 can take new data when empty or when it moves into S2.
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_hold    <= Y_DEF_W;
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_a      <= '0;
      s1_branch <= BR_ELSE;
      s2_valid  <= 1'b0;
      s2_o1     <= '0;
      s2_o2     <= '0;
      s2_branch <= BR_ELSE;
    end else begin
      // The outer-if leg is exactly the set of branches other than BR_ELSE.
      if (accept && (sel_branch != BR_ELSE)) begin
        y_hold <= e;
      end

      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_x      <= sel_x;
          s1_y      <= sel_y;
          s1_a      <= a;
          s1_branch <= sel_branch;
        end
      end

      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_o1     <= {1'b0, s1_x} + {1'b0, s1_a};
          s2_o2     <= {1'b0, s1_y} + {1'b0, s1_a};
          s2_branch <= s1_branch;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign o1        = s2_o1;
  assign o2        = s2_o2;
  assign branch    = s2_branch;

endmodule

// File: tb/tb_nested_if_pipe.sv
// tb_nested_if_pipe: checks nested_if_pipe (defaults) and a TH_HI=2 copy driven
// by the same stimulus, against a transaction-level model: a 2-entry in-flight
// queue where the front entry becomes visible once it reaches the output slot.
module tb_nested_if_pipe;

  localparam int W         = 4;
  localparam int TH_LO     = 1;
  localparam int TH_MID    = 2;
  localparam int TH_HI     = 3;
  localparam int TH_HI_B   = 2;
  localparam int Y_DEFAULT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0;

  logic         in_ready, out_valid, in_ready_b, out_valid_b;
  logic [W:0]   o1, o2, o1_b, o2_b;
  logic [1:0]   branch, branch_b;

  nested_if_pipe #(.WIDTH(W), .TH_LO(TH_LO), .TH_MID(TH_MID), .TH_HI(TH_HI),
                   .Y_DEFAULT(Y_DEFAULT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .out_valid(out_valid), .out_ready(out_ready), .o1(o1), .o2(o2), .branch(branch)
  );

  nested_if_pipe #(.WIDTH(W), .TH_LO(TH_LO), .TH_MID(TH_MID), .TH_HI(TH_HI_B),
                   .Y_DEFAULT(Y_DEFAULT)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .mode(mode), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .out_valid(out_valid_b), .out_ready(out_ready), .o1(o1_b), .o2(o2_b), .branch(branch_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W:0] o1, o2, o1b, o2b;
    logic [1:0] br, brb;
    bit         in_out;   // entry has reached the output slot
    bit         lit;
    bit         lit_sel;  // 0 = default instance, 1 = TH_HI=2 instance
    logic [W:0] lo1, lo2;
    logic [1:0] lbr;
  } ent_t;

  ent_t exp_q[$];
  int   y_hold_m = Y_DEFAULT;
  int   acc_cnt = 0;
  bit   rst_chk = 0;
  int   checks = 0;
  int   fails = 0;

  bit         lit_on = 0, lit_sel = 0;
  logic [W:0] lit_o1 = '0, lit_o2 = '0;
  logic [1:0] lit_br = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Selection rules evaluated directly on integers.
  function automatic void ref_sel(input int av, bv, cv, dv, ev, fv, input bit m,
                                  input int yh, input int th_hi,
                                  output int o1v, output int o2v, output int brv);
    int xv, yv;
    yv = m ? yh : (Y_DEFAULT % (1 << W));
    if (av > TH_LO) begin
      yv = ev;
      if (av > TH_MID)          begin xv = bv; brv = 1; end
      else if (av + 1 > th_hi)  begin xv = cv; brv = 2; end
      else                      begin xv = dv; brv = 3; end
    end else begin
      xv = fv; brv = 0;
    end
    o1v = xv + av;
    o2v = yv + av;
  endfunction

  // Pipe holds at most two transactions; it refuses only when full and stalled.
  function automatic bit exp_ready();
    return (exp_q.size() < 2) || out_ready;
  endfunction

  function automatic bit exp_valid();
    return (exp_q.size() > 0) && exp_q[0].in_out;
  endfunction

  task automatic model_step();
    ent_t n, h;
    int   r1, r2, rb;
    bit   rdy;
    if (reset) begin
      exp_q.delete();
      y_hold_m = Y_DEFAULT;
      rst_chk  = 1;
    end else begin
      rdy = exp_ready();
      if (exp_valid() && out_ready) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && !exp_q[0].in_out) begin
        h = exp_q.pop_front();
        h.in_out = 1;
        exp_q.push_front(h);
      end
      if (in_valid && rdy) begin
        ref_sel(a, b, c, d, e, f, mode, y_hold_m, TH_HI, r1, r2, rb);
        n.o1 = (W+1)'(r1); n.o2 = (W+1)'(r2); n.br = 2'(rb);
        ref_sel(a, b, c, d, e, f, mode, y_hold_m, TH_HI_B, r1, r2, rb);
        n.o1b = (W+1)'(r1); n.o2b = (W+1)'(r2); n.brb = 2'(rb);
        n.in_out = 0;
        n.lit = lit_on; n.lit_sel = lit_sel;
        n.lo1 = lit_o1; n.lo2 = lit_o2; n.lbr = lit_br;
        exp_q.push_back(n);
        if (int'(a) > TH_LO) y_hold_m = int'(e);
        acc_cnt++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("in_ready", in_ready, exp_ready());
      chk("in_ready_b", in_ready_b, exp_ready());
      chk("out_valid", out_valid, exp_valid());
      chk("out_valid_b", out_valid_b, exp_valid());
      if (exp_valid()) begin
        chk("o1", o1, exp_q[0].o1);
        chk("o2", o2, exp_q[0].o2);
        chk("branch", branch, exp_q[0].br);
        chk("o1_b", o1_b, exp_q[0].o1b);
        chk("o2_b", o2_b, exp_q[0].o2b);
        chk("branch_b", branch_b, exp_q[0].brb);
        if (exp_q[0].lit) begin
          chk("lit_o1", exp_q[0].lit_sel ? o1_b : o1, exp_q[0].lo1);
          chk("lit_o2", exp_q[0].lit_sel ? o2_b : o2, exp_q[0].lo2);
          chk("lit_branch", exp_q[0].lit_sel ? branch_b : branch, exp_q[0].lbr);
        end
      end
      if (rst_chk) begin
        chk("rst_o1", o1, 0);
        chk("rst_o2", o2, 0);
        chk("rst_branch", branch, 0);
        chk("rst_o1_b", o1_b, 0);
        rst_chk = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int av, bv, cv, dv, ev, fv, input bit m,
                      input bit lo, input bit ls, input int l1, l2, lb);
    bit acc;
    a = W'(av); b = W'(bv); c = W'(cv); d = W'(dv); e = W'(ev); f = W'(fv);
    mode = m; in_valid = 1'b1;
    lit_on = lo; lit_sel = ls; lit_o1 = (W+1)'(l1); lit_o2 = (W+1)'(l2); lit_br = 2'(lb);
    acc = 0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = exp_ready();
      @(posedge clk); #2;
    end
    chk("send_accepted", acc, 1);
    in_valid = 1'b0;
    lit_on = 0;
  endtask

  task automatic send_rand();
    send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
         1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      @(posedge clk); #2;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;

    // Outer-if leg with a > TH_MID: x = b, y = e.
    send(3, 7, 0, 0, 9, 0, 0, 1, 0, 10, 12, 1);
    wait_empty();

    // a = 2: d leg with defaults (c leg in the TH_HI=2 copy); then outer else.
    send(2, 0, 0, 4, 6, 0, 0, 1, 0, 6, 8, 3);
    send(1, 0, 0, 0, 0, 5, 0, 1, 0, 6, 6, 0);
    wait_empty();

    // c leg in the TH_HI=2 copy; full-width sums.
    send(2, 0, 11, 0, 1, 0, 0, 1, 1, 13, 3, 2);
    send(15, 15, 0, 0, 15, 0, 0, 1, 0, 30, 30, 1);
    wait_empty();

    // Sticky y picks up the last accepted outer-if e.
    send(5, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    send(0, 0, 0, 0, 0, 3, 1, 1, 0, 3, 12, 0);
    wait_empty();

    // Backpressure: only two accepts fit while the output is stalled.
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_accepts", acc_cnt - base, 2);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("bp_total", acc_cnt - base, 4);

    // Reset with both stages full discards everything and restores y_hold.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    pulse_reset();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(0, 0, 0, 0, 0, 3, 1, 1, 0, 3, 5, 0);
    wait_empty();

    // Randomized traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15));
      c = W'($urandom_range(0, 15)); d = W'($urandom_range(0, 15));
      e = W'($urandom_range(0, 15)); f = W'($urandom_range(0, 15));
      @(posedge clk); #2;
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
